calc_op_sequencer: RTL and testbench

//  Command sequencer for the 16x16 calculator datapath.
//  - Accepts one operation (a, b, op_code) per valid/ready handshake; registers operands.
//  - Executes add/sub/mul in a single cycle; executes divide as a 16-step restoring loop.
//  - Presents a registered 32-bit result with valid/ready.
//  - Sits between the keypad/UART command decoder and the display/result formatter.

---
 rtl/calc_op_sequencer.sv | 132 +++++++++++++
 tb/tb_calc_op_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// Operation sequencer for the calculator datapath: single-cycle add/sub/mul, WIDTH-step restoring divide.
// Optional macro CALC_CHAIN_EN adds a 'chain' input that reuses the last delivered result as operand A.
module calc_op_sequencer #(
    parameter int         WIDTH  = 16,
    parameter logic [7:0] OP_ADD = 8'd43,
    parameter logic [7:0] OP_SUB = 8'd45,
    parameter logic [7:0] OP_MUL = 8'd42,
    parameter logic [7:0] OP_DIV = 8'd47
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [7:0]           op_code,
`ifdef CALC_CHAIN_EN
    input  logic                 chain,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 err,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q;
    logic [7:0]       op_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] a_sel, rem_nx, quo_nx;
    logic [WIDTH:0]   rem_sh, diff;
    logic             fits;

`ifdef CALC_CHAIN_EN
    logic [2*WIDTH-1:0] last_res;
    assign a_sel = chain ? last_res[WIDTH-1:0] : a;
`else
    assign a_sel = a;
`endif

    // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        fits   = (rem_sh >= {1'b0, b_q});
        rem_nx = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
`ifdef CALC_CHAIN_EN
            last_res  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_sel;
                        b_q      <= b;
                        op_q     <= op_code;
                        rem_q    <= '0;
                        quo_q    <= a_sel;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (op_code == OP_DIV && b != '0) ? DIV : EXEC;
                    end
                end
                EXEC: begin
                    err <= 1'b0;
                    case (op_q)
                        OP_ADD: y <= {{(WIDTH-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
                        OP_SUB: y <= {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
                        OP_MUL: y <= {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
                        OP_DIV: begin
                            y   <= '1;
                            err <= 1'b1;
                        end
                        default: begin
                            y   <= '0;
                            err <= 1'b1;
                        end
                    endcase
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        y         <= {rem_nx, quo_nx};
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef CALC_CHAIN_EN
                        last_res  <= y;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: hand-computed results, latencies, hold and reset behaviour.
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic        in_ready, out_valid, err, busy;
    logic [15:0] a, b;
    logic [7:0]  op_code;
    logic [31:0] y;
`ifdef CALC_CHAIN_EN
    logic        chain;
`endif

    int npass = 0;
    int ntotal = 0;

    calc_op_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_code(op_code),
`ifdef CALC_CHAIN_EN
        .chain(chain),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one command; returns edges from accept (counted as 1) to the edge raising out_valid.
    task automatic run_cmd(input logic [15:0] av, input logic [15:0] bv, input logic [7:0] op,
                           output int lat, output logic busy_all);
        @(posedge clk); #1;
        a = av; b = bv; op_code = op; in_valid = 1'b1;
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; op_code = 8'd0;
        lat = 1;
        busy_all = busy;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            busy_all &= busy;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic bz;
        logic [31:0] saved;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op_code = '0;
`ifdef CALC_CHAIN_EN
        chain = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // out_ready while idle must be ignored
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_ready_ignored", {31'd0, out_valid}, 32'd0);

        run_cmd(16'd3, 16'd5, 8'd43, lat, bz);
        chk("add_y", y, 32'h0000_0008);
        chk("add_err", {31'd0, err}, 32'd0);
        chk("add_lat", lat, 2);
        take();

        run_cmd(16'hFFFF, 16'h0001, 8'd43, lat, bz);
        chk("add_carry_y", y, 32'h0001_0000);
        take();

        run_cmd(16'd2, 16'd7, 8'd45, lat, bz);
        chk("sub_y", y, 32'hFFFF_FFFB);
        chk("sub_err", {31'd0, err}, 32'd0);
        chk("sub_lat", lat, 2);
        take();

        run_cmd(16'hFFFF, 16'hFFFF, 8'd42, lat, bz);
        chk("mul_y", y, 32'hFFFE_0001);
        chk("mul_lat", lat, 2);
        take();

        run_cmd(16'd100, 16'd7, 8'd47, lat, bz);
        chk("div_y", y, {16'd2, 16'd14});
        chk("div_err", {31'd0, err}, 32'd0);
        chk("div_lat", lat, 17);
        chk("div_busy", {31'd0, bz}, 32'd1);
        take();

        run_cmd(16'hFFFF, 16'd1, 8'd47, lat, bz);
        chk("div_by1_y", y, 32'h0000_FFFF);
        take();

        run_cmd(16'd9, 16'd0, 8'd47, lat, bz);
        chk("div0_y", y, 32'hFFFF_FFFF);
        chk("div0_err", {31'd0, err}, 32'd1);
        chk("div0_lat", lat, 2);
        take();

        run_cmd(16'd9, 16'd4, 8'd37, lat, bz);
        chk("illegal_y", y, 32'd0);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_lat", lat, 2);
        take();

        // Hold the result with out_ready low while a new command is offered.
        run_cmd(16'd1000, 16'd24, 8'd42, lat, bz);
        saved = 32'd24000;
        in_valid = 1'b1; a = 16'd1; b = 16'd1; op_code = 8'd43;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_y", y, saved);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        take();
        @(posedge clk); #1;
        chk("no_ghost_cmd", {31'd0, busy}, 32'd0);

        // Reset during the divide loop, around step 8.
        @(posedge clk); #1;
        a = 16'd500; b = 16'd3; op_code = 8'd47; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("div_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_result", {31'd0, out_valid}, 32'd0);

        run_cmd(16'd3, 16'd5, 8'd43, lat, bz);
        chk("post_rst_add_y", y, 32'h0000_0008);
        chk("post_rst_add_lat", lat, 2);
        take();

`ifdef CALC_CHAIN_EN
        run_cmd(16'd6, 16'd4, 8'd43, lat, bz);
        chk("chain_seed_y", y, 32'd10);
        take();
        chain = 1'b1;
        run_cmd(16'd999, 16'd3, 8'd42, lat, bz);
        chain = 1'b0;
        chk("chain_mul_y", y, 32'd30);
        take();
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
